// File: rtl/sv39_ptw.sv
// -----------------------------------------------------------------------------
// sv39_ptw -- hardware page-table walker for the RISC-V Sv39 scheme.
//
// On a TLB miss the walker reads up to three PTEs, starting from the root
// table given by satp_ppn_i. It either produces a one-cycle TLB fill or a
// one-cycle page-fault pulse. flush_i aborts a walk at any point, and an
// already-issued memory read is drained silently.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              abort the current walk and suppress its result
//   satp_ppn_i           root page-table PPN (sampled when a walk is accepted)
//   asid_i               ASID tagged onto the walk
//   walk_valid_i/_ready_o, walk_vaddr_i   TLB-miss request (valid/ready)
//   mem_req_valid_o/_ready_i, mem_req_addr_o   PTE read request (valid/ready)
//   mem_rsp_valid_i, mem_rsp_data_i      PTE read data, no backpressure
//   update_*             TLB fill (update_valid_o is a one-cycle pulse)
//   walk_error_o         page-fault pulse
//   busy_o               walker is not idle
// -----------------------------------------------------------------------------
module sv39_ptw #(
  parameter int unsigned ASID_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [43:0]           satp_ppn_i,
  input  logic [ASID_WIDTH-1:0] asid_i,
  input  logic                  walk_valid_i,
  output logic                  walk_ready_o,
  input  logic [38:0]           walk_vaddr_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [55:0]           mem_req_addr_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [63:0]           mem_rsp_data_i,
  output logic                  update_valid_o,
  output logic [26:0]           update_vpn_o,
  output logic [ASID_WIDTH-1:0] update_asid_o,
  output logic [63:0]           update_content_o,
  output logic                  update_is_2M_o,
  output logic                  update_is_1G_o,
  output logic                  walk_error_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ABORT
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;

  logic [38:0]           r_vaddr;
  logic [ASID_WIDTH-1:0] r_asid;
  logic [43:0]           r_ppn;     // base PPN of the table being read
  logic [1:0]            r_level;
  logic                  r_update_valid;
  logic                  r_walk_error;
  logic [63:0]           r_content;
  logic                  r_is_1G;
  logic                  r_is_2M;

  logic                  w_accept;
  logic [8:0]            w_vpn;
  logic                  w_pte_v, w_pte_r, w_pte_w, w_pte_x;
  logic [43:0]           w_pte_ppn;
  logic                  w_take;
  logic                  w_bad_perm;
  logic                  w_leaf;
  logic                  w_misaligned;
  logic                  w_fill;
  logic                  w_descend;
  logic                  w_fault;

  assign w_pte_v   = mem_rsp_data_i[0];
  assign w_pte_r   = mem_rsp_data_i[1];
  assign w_pte_w   = mem_rsp_data_i[2];
  assign w_pte_x   = mem_rsp_data_i[3];
  assign w_pte_ppn = mem_rsp_data_i[53:10];

  // A response is only acted on in WAIT without a flush; a coincident
  // flush discards it.
  assign w_take       = (r_state == S_WAIT) && mem_rsp_valid_i && !flush_i;
  assign w_bad_perm   = !w_pte_v || (!w_pte_r && w_pte_w);
  assign w_leaf       = w_pte_r || w_pte_x;
  // Superpage leaves must have PPN bits below their page size cleared.
  assign w_misaligned = ((r_level == 2'd2) && (|w_pte_ppn[17:0])) ||
                        ((r_level == 2'd1) && (|w_pte_ppn[8:0]));
  assign w_fill       = w_take && !w_bad_perm && w_leaf && !w_misaligned;
  assign w_descend    = w_take && !w_bad_perm && !w_leaf && (r_level != 2'd0);
  assign w_fault      = w_take && !w_fill && !w_descend;

  assign w_accept     = walk_valid_i && walk_ready_o;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_vpn = r_vaddr[20:12];
    case (r_level)
      2'd2:    w_vpn = r_vaddr[38:30];
      2'd1:    w_vpn = r_vaddr[29:21];
      default: w_vpn = r_vaddr[20:12];
    endcase
  end

  // Built only from registers, so the address holds while the request stalls.
  assign mem_req_addr_o = {r_ppn, w_vpn, 3'b000};

  // ---------------------------------------------------------------- state reg
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_REQ;
      S_REQ: begin
        if (flush_i)              w_state_nxt = mem_req_ready_i ? S_ABORT : S_IDLE;
        else if (mem_req_ready_i) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (flush_i)              w_state_nxt = mem_rsp_valid_i ? S_IDLE : S_ABORT;
        else if (mem_rsp_valid_i) w_state_nxt = w_descend ? S_REQ : S_IDLE;
      end
      S_ABORT: if (mem_rsp_valid_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    walk_ready_o    = 1'b0;
    mem_req_valid_o = 1'b0;
    busy_o          = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy_o       = 1'b0;
        // Hold off a new walk during the fill/fault pulse cycle.
        walk_ready_o = !flush_i && !r_update_valid && !r_walk_error;
      end
      S_REQ:   mem_req_valid_o = 1'b1;
      default: ;
    endcase
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vaddr        <= '0;
      r_asid         <= '0;
      r_ppn          <= '0;
      r_level        <= '0;
      r_update_valid <= 1'b0;
      r_walk_error   <= 1'b0;
      r_content      <= '0;
      r_is_1G        <= 1'b0;
      r_is_2M        <= 1'b0;
    end else begin
      r_update_valid <= w_fill;
      r_walk_error   <= w_fault;
      if (w_accept) begin
        r_vaddr <= walk_vaddr_i;
        r_asid  <= asid_i;
        r_ppn   <= satp_ppn_i;
        r_level <= 2'd2;
      end else if (w_descend) begin
        r_ppn   <= w_pte_ppn;
        r_level <= r_level - 2'd1;
      end
      if (w_fill) begin
        r_content <= mem_rsp_data_i;
        r_is_1G   <= (r_level == 2'd2);
        r_is_2M   <= (r_level == 2'd1);
      end
    end
  end

  assign update_valid_o   = r_update_valid;
  assign update_vpn_o     = r_vaddr[38:12];
  assign update_asid_o    = r_asid;
  assign update_content_o = r_content;
  assign update_is_1G_o   = r_is_1G;
  assign update_is_2M_o   = r_is_2M;
  assign walk_error_o     = r_walk_error;

endmodule

// File: tb/tb_sv39_ptw.sv
// -----------------------------------------------------------------------------
// tb_sv39_ptw -- self-checking bench for sv39_ptw.
// A sparse page table (associative array) backs a memory model with random
// ready and latency. Each walk's expected outcome comes from a direct
// Sv39 translation routine over the same table.
// -----------------------------------------------------------------------------
module tb_sv39_ptw;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic [43:0] satp_ppn_i;
  logic [3:0]  asid_i;
  logic        walk_valid_i;
  logic        walk_ready_o;
  logic [38:0] walk_vaddr_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [55:0] mem_req_addr_o;
  logic        mem_rsp_valid_i;
  logic [63:0] mem_rsp_data_i;
  logic        update_valid_o;
  logic [26:0] update_vpn_o;
  logic [3:0]  update_asid_o;
  logic [63:0] update_content_o;
  logic        update_is_2M_o;
  logic        update_is_1G_o;
  logic        walk_error_o;
  logic        busy_o;

  sv39_ptw #(.ASID_WIDTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .satp_ppn_i(satp_ppn_i), .asid_i(asid_i),
    .walk_valid_i(walk_valid_i), .walk_ready_o(walk_ready_o),
    .walk_vaddr_i(walk_vaddr_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
    .update_valid_o(update_valid_o), .update_vpn_o(update_vpn_o),
    .update_asid_o(update_asid_o), .update_content_o(update_content_o),
    .update_is_2M_o(update_is_2M_o), .update_is_1G_o(update_is_1G_o),
    .walk_error_o(walk_error_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // ------------------------------------------------------------ page table
  logic [63:0] pt [logic [55:0]];

  function automatic logic [63:0] mem_rd(input logic [55:0] a);
    return pt.exists(a) ? pt[a] : 64'h0;
  endfunction

  function automatic logic [63:0] mk_pte(input logic [43:0] ppn, input logic [3:0] xwrv);
    return {10'h0, ppn, 6'h0, xwrv};
  endfunction

  // ---------------------------------------------------- memory + monitor
  int          ready_mode = 0;   // 0: always ready, 1: random
  int          lat_min = 1, lat_max = 1;
  int          stall_left = 0;
  int          countdown = 0;
  logic [55:0] pend_addr;
  int          nc = 0, last_rsp_nc = 0;
  int          rsp_cnt = 0, req_cnt = 0, fill_cnt = 0, err_cnt = 0, stall_cycles = 0;
  logic [55:0] obs_addrs[$];
  logic [63:0] obs_content;
  logic [26:0] obs_vpn;
  logic [3:0]  obs_asid;
  logic        obs_1g, obs_2m;
  logic        prev_stall = 1'b0;
  logic [55:0] prev_addr;

  initial forever begin
    @(negedge clk_i);
    nc++;
    if (rst_ni) begin
      if (update_valid_o || walk_error_o) begin
        check("pulse_exclusive", {63'h0, update_valid_o & walk_error_o}, 64'h0);
        check("pulse_no_accept", {63'h0, walk_ready_o}, 64'h0);
        check("pulse_latency", nc - last_rsp_nc, 1);
      end
      if (update_valid_o) begin
        fill_cnt++;
        obs_content = update_content_o;
        obs_vpn     = update_vpn_o;
        obs_asid    = update_asid_o;
        obs_1g      = update_is_1G_o;
        obs_2m      = update_is_2M_o;
      end
      if (walk_error_o) err_cnt++;
      if (prev_stall && mem_req_valid_o) check("addr_stable", mem_req_addr_o, prev_addr);
    end
    mem_rsp_valid_i = 1'b0;
    if (countdown > 0) begin
      countdown--;
      if (countdown == 0) begin
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = mem_rd(pend_addr);
        last_rsp_nc     = nc;
        rsp_cnt++;
      end
    end
    if (stall_left > 0) begin
      mem_req_ready_i = 1'b0;
      stall_left--;
    end else if (ready_mode == 1) mem_req_ready_i = ($urandom_range(0, 3) != 0);
    else                          mem_req_ready_i = 1'b1;
    if (rst_ni && mem_req_valid_o && mem_req_ready_i) begin
      obs_addrs.push_back(mem_req_addr_o);
      pend_addr = mem_req_addr_o;
      countdown = int'($urandom_range(lat_min, lat_max));
      req_cnt++;
    end
    if (rst_ni && mem_req_valid_o && !mem_req_ready_i) stall_cycles++;
    prev_stall = rst_ni && mem_req_valid_o && !mem_req_ready_i;
    prev_addr  = mem_req_addr_o;
  end

  // ------------------------------------------------- reference translation
  logic [55:0] exp_addrs[$];
  logic        exp_fill;
  logic [63:0] exp_content;
  int          exp_lvl;

  task automatic model(input logic [43:0] satp, input logic [38:0] va);
    logic [55:0] table_base;
    logic [55:0] addr;
    logic [63:0] pte;
    logic [63:0] ppn;
    exp_addrs.delete();
    exp_fill   = 1'b0;
    table_base = {satp, 12'h0};
    for (int lvl = 2; lvl >= 0; lvl--) begin
      addr = table_base + 56'(((va >> (12 + 9 * lvl)) & 39'h1ff) * 8);
      exp_addrs.push_back(addr);
      pte = mem_rd(addr);
      if (!pte[0] || (!pte[1] && pte[2])) return;
      ppn = 64'(pte[53:10]);
      if (pte[1] || pte[3]) begin
        if ((ppn % (64'd1 << (9 * lvl))) != 0) return;
        exp_fill    = 1'b1;
        exp_content = pte;
        exp_lvl     = lvl;
        return;
      end
      table_base = 56'(ppn * 4096);
    end
  endtask

  task automatic build_random(input logic [43:0] satp, input logic [38:0] va);
    logic [55:0] table_base;
    logic [55:0] addr;
    logic [63:0] pte;
    logic [43:0] ppn;
    logic        r, x;
    int          kind;
    pt.delete();
    table_base = {satp, 12'h0};
    for (int lvl = 2; lvl >= 0; lvl--) begin
      addr = table_base + 56'(((va >> (12 + 9 * lvl)) & 39'h1ff) * 8);
      kind = int'($urandom_range(0, 9));
      pte  = {$urandom(), $urandom()};
      ppn  = 44'({$urandom(), $urandom()});
      if (kind == 0) begin
        pte[0] = 1'b0;
        pt[addr] = pte;
        return;
      end
      pte[0] = 1'b1;
      if (kind == 1) begin
        pte[3:1] = 3'b010;
        pt[addr] = pte;
        return;
      end
      if (kind <= 4) begin
        r = 1'($urandom_range(0, 1));
        x = 1'($urandom_range(0, 1));
        if (!r && !x) r = 1'b1;
        pte[1] = r;
        pte[2] = r & 1'($urandom_range(0, 1));
        pte[3] = x;
        if ($urandom_range(0, 1) != 0) ppn = ppn & ~44'((64'd1 << (9 * lvl)) - 1);
        pte[53:10] = ppn;
        pt[addr] = pte;
        return;
      end
      pte[3:1]   = 3'b000;
      pte[53:10] = ppn;
      pt[addr]   = pte;
      table_base = {ppn, 12'h0};
    end
  endtask

  // --------------------------------------------------------- walk drivers
  task automatic start_walk(input logic [43:0] satp, input logic [38:0] va, input logic [3:0] asid);
    int k = 0;
    while (!walk_ready_o && k < 100) begin
      cyc();
      k++;
    end
    check("walk_ready_wait", {63'h0, walk_ready_o}, 64'h1);
    satp_ppn_i   = satp;
    walk_vaddr_i = va;
    asid_i       = asid;
    walk_valid_i = 1'b1;
    cyc();
    walk_valid_i = 1'b0;
    check("first_req_cycle", {63'h0, mem_req_valid_o}, 64'h1);
  endtask

  task automatic do_walk(input string tag, input logic [43:0] satp, input logic [38:0] va,
                         input logic [3:0] asid);
    int f0, e0, k;
    model(satp, va);
    f0 = fill_cnt;
    e0 = err_cnt;
    obs_addrs.delete();
    start_walk(satp, va, asid);
    k = 0;
    while (fill_cnt == f0 && err_cnt == e0 && k < 300) begin
      cyc();
      k++;
    end
    check({tag, "_done"}, {63'h0, (fill_cnt != f0) || (err_cnt != e0)}, 64'h1);
    cyc();
    cyc();
    check({tag, "_nreq"}, obs_addrs.size(), exp_addrs.size());
    for (int i = 0; i < exp_addrs.size() && i < obs_addrs.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), obs_addrs[i], exp_addrs[i]);
    check({tag, "_fills"}, fill_cnt - f0, exp_fill ? 1 : 0);
    check({tag, "_errors"}, err_cnt - e0, exp_fill ? 0 : 1);
    if (exp_fill && fill_cnt - f0 == 1) begin
      check({tag, "_content"}, obs_content, exp_content);
      check({tag, "_vpn"}, obs_vpn, va[38:12]);
      check({tag, "_asid"}, obs_asid, asid);
      check({tag, "_is1g"}, obs_1g, exp_lvl == 2);
      check({tag, "_is2m"}, obs_2m, exp_lvl == 1);
    end
  endtask

  // Waits for the drained response of an aborted walk, then checks the
  // walker is idle again with no fill or fault produced.
  task automatic wait_abort_done(input string tag, input int rsp0, input int f0, input int e0);
    int   k = 0;
    logic seen = 1'b0;
    logic busy_ok = 1'b1;
    while (!seen && k < 50) begin
      if (rsp_cnt != rsp0) seen = 1'b1;
      else begin
        if (!busy_o) busy_ok = 1'b0;
        cyc();
        k++;
      end
    end
    check({tag, "_rsp_seen"}, {63'h0, seen}, 64'h1);
    check({tag, "_busy_until_rsp"}, {63'h0, busy_ok}, 64'h1);
    check({tag, "_ready_after"}, {63'h0, walk_ready_o}, 64'h1);
    repeat (3) cyc();
    check({tag, "_no_fill"}, fill_cnt - f0, 0);
    check({tag, "_no_error"}, err_cnt - e0, 0);
  endtask

  task automatic set_chain();
    pt.delete();
    pt[56'h100008] = mk_pte(44'h200, 4'h1);
    pt[56'h200008] = mk_pte(44'h300, 4'h1);
    pt[56'h300008] = mk_pte(44'h80000, 4'hF);
  endtask

  // ------------------------------------------------------------- sequence
  initial begin
    logic [43:0] satp;
    logic [38:0] va;
    int          f0, e0, r0, k;
    rst_ni = 1'b0; flush_i = 1'b0; satp_ppn_i = '0; asid_i = '0;
    walk_valid_i = 1'b0; walk_vaddr_i = '0;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
    repeat (2) cyc();
    check("rst_ready", {63'h0, walk_ready_o}, 64'h1);
    check("rst_busy", {63'h0, busy_o}, 64'h0);
    check("rst_req_valid", {63'h0, mem_req_valid_o}, 64'h0);
    check("rst_req_addr", mem_req_addr_o, 64'h0);
    check("rst_update", {63'h0, update_valid_o}, 64'h0);
    check("rst_error", {63'h0, walk_error_o}, 64'h0);
    check("rst_content", update_content_o, 64'h0);
    check("rst_vpn", update_vpn_o, 64'h0);
    rst_ni = 1'b1;
    cyc();
    flush_i = 1'b1;
    #1 check("idle_flush_ready", {63'h0, walk_ready_o}, 64'h0);
    flush_i = 1'b0;
    #1 check("idle_ready", {63'h0, walk_ready_o}, 64'h1);

    // 4 KiB walk through three levels, zero-wait memory
    ready_mode = 0; lat_min = 1; lat_max = 1;
    set_chain();
    do_walk("d4k", 44'h100, 39'h40201000, 4'h5);
    check("d4k_a0", obs_addrs[0], 56'h100008);
    check("d4k_a1", obs_addrs[1], 56'h200008);
    check("d4k_a2", obs_addrs[2], 56'h300008);
    check("d4k_vpn_c", obs_vpn, 27'h40201);
    check("d4k_1g_c", obs_1g, 0);
    check("d4k_2m_c", obs_2m, 0);

    // gigapage leaf: aligned fills, misaligned faults
    pt.delete();
    pt[56'h100008] = mk_pte(44'h40000, 4'hF);
    do_walk("d1g", 44'h100, 39'h40201000, 4'h3);
    check("d1g_nreq_c", obs_addrs.size(), 1);
    check("d1g_1g_c", obs_1g, 1);
    pt[56'h100008] = mk_pte(44'h40001, 4'hF);
    do_walk("d1g_mis", 44'h100, 39'h40201000, 4'h3);

    // invalid level-1 PTE, then a reserved R=0/W=1 encoding
    pt.delete();
    pt[56'h100008] = mk_pte(44'h200, 4'h1);
    do_walk("dinv", 44'h100, 39'h40201000, 4'h1);
    check("dinv_nreq_c", obs_addrs.size(), 2);
    pt[56'h100008] = mk_pte(44'h200, 4'h5);
    do_walk("drw", 44'h100, 39'h40201000, 4'h1);

    // memory holds ready low while the first request is pending
    set_chain();
    k = stall_cycles;
    stall_left = 5;
    do_walk("dstall", 44'h100, 39'h40201000, 4'h2);
    check("dstall_cycles", stall_cycles - k, 4);

    // flush in WAIT, response five cycles later
    lat_min = 6; lat_max = 6;
    f0 = fill_cnt; e0 = err_cnt; r0 = rsp_cnt;
    start_walk(44'h100, 39'h40201000, 4'h0);
    cyc();
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    wait_abort_done("fl_wait", r0, f0, e0);

    // flush coincident with the request handshake
    lat_min = 3; lat_max = 3;
    f0 = fill_cnt; e0 = err_cnt; r0 = rsp_cnt;
    start_walk(44'h100, 39'h40201000, 4'h0);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    check("fl_hs_no_req", {63'h0, mem_req_valid_o}, 64'h0);
    wait_abort_done("fl_hs", r0, f0, e0);

    // flush in REQ before any handshake
    f0 = fill_cnt; e0 = err_cnt; r0 = req_cnt;
    stall_left = 4;
    start_walk(44'h100, 39'h40201000, 4'h0);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    #1;
    check("fl_req_ready", {63'h0, walk_ready_o}, 64'h1);
    check("fl_req_busy", {63'h0, busy_o}, 64'h0);
    check("fl_req_no_hs", req_cnt - r0, 0);
    repeat (4) cyc();

    // flush in the same cycle as the response
    lat_min = 1; lat_max = 1;
    f0 = fill_cnt; e0 = err_cnt;
    start_walk(44'h100, 39'h40201000, 4'h0);
    cyc();
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    check("fl_rsp_idle", {63'h0, busy_o}, 64'h0);
    repeat (3) cyc();
    check("fl_rsp_no_fill", fill_cnt - f0, 0);
    check("fl_rsp_no_error", err_cnt - e0, 0);

    // reset during the level-1 WAIT, stray response arrives afterwards
    lat_min = 4; lat_max = 4;
    f0 = fill_cnt; e0 = err_cnt; r0 = req_cnt;
    start_walk(44'h100, 39'h40201000, 4'h7);
    k = 0;
    while (req_cnt - r0 < 2 && k < 50) begin
      cyc();
      k++;
    end
    check("rstw_reached_l1", req_cnt - r0, 2);
    rst_ni = 1'b0;
    #1;
    check("rstw_ready", {63'h0, walk_ready_o}, 64'h1);
    check("rstw_busy", {63'h0, busy_o}, 64'h0);
    check("rstw_req_valid", {63'h0, mem_req_valid_o}, 64'h0);
    check("rstw_addr", mem_req_addr_o, 64'h0);
    cyc();
    cyc();
    rst_ni = 1'b1;
    repeat (8) cyc();
    check("rstw_no_fill", fill_cnt - f0, 0);
    check("rstw_no_error", err_cnt - e0, 0);
    check("rstw_idle_ready", {63'h0, walk_ready_o}, 64'h1);

    // randomized tables, ready and latency
    ready_mode = 1; lat_min = 1; lat_max = 3;
    for (int t = 0; t < 250; t++) begin
      satp = 44'({$urandom(), $urandom()});
      va   = 39'({$urandom(), $urandom()});
      build_random(satp, va);
      do_walk("rnd", satp, va, 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sv39_ptw.md
SV39_PTW -- requirements
Module: sv39_ptw

Interface
REQ-001 SHALL have parameter ASID_WIDTH, default 1, giving the ASID tag width (must be >= 1).
REQ-002 SHALL have port clk_i  in  1  clock; reset rst_ni, asynchronous, active-low.
REQ-003 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-004 SHALL have port flush_i  in  1  abort walk, suppress result.
REQ-005 SHALL have port satp_ppn_i  in  44  root page-table PPN.
REQ-006 SHALL have port asid_i  in  ASID_WIDTH  ASID captured with each walk.
REQ-007 SHALL have ports walk_valid_i in 1, walk_ready_o out 1, walk_vaddr_i in 39: the TLB-miss request.
REQ-008 SHALL have ports mem_req_valid_o out 1, mem_req_ready_i in 1, mem_req_addr_o out 56: PTE read request.
REQ-009 SHALL have ports mem_rsp_valid_i in 1, mem_rsp_data_i in 64: PTE read data, one response per accepted request, no backpressure.
REQ-010 SHALL have outputs update_valid_o 1, update_vpn_o 27, update_asid_o ASID_WIDTH, update_content_o 64, update_is_2M_o 1, update_is_1G_o 1: TLB fill.
REQ-011 SHALL have outputs walk_error_o 1 (page-fault pulse) and busy_o 1.

Function
REQ-012 SHALL implement states IDLE, REQ, WAIT, ABORT.
REQ-013 IDLE: walk_ready_o=1 and flush_i=0; on walk_valid_i capture vaddr and asid_i, set level=2, go REQ.
REQ-014 REQ: mem_req_valid_o=1; addr = {base_ppn, vpn[level], 3'b000}, base_ppn = satp_ppn_i on level 2 else the captured PTE PPN; on mem_req_ready_i go WAIT.
REQ-015 mem_req_addr_o SHALL remain stable while mem_req_valid_o=1 and mem_req_ready_i=0.
REQ-016 vpn[2]=vaddr[38:30], vpn[1]=vaddr[29:21], vpn[0]=vaddr[20:12]; PTE bits V=0,R=1,W=2,X=3,G=5, PPN=[53:10].
REQ-017 WAIT, on mem_rsp_valid_i: fault if V=0, or R=0 and W=1; leaf if R|X; otherwise pointer.
REQ-018 Pointer PTE at level>0: store PPN, decrement level, go REQ; at level 0: fault.
REQ-019 Leaf at level 2 with PPN[17:0]!=0, or at level 1 with PPN[8:0]!=0: fault (misaligned superpage).
REQ-020 Valid leaf: next cycle update_valid_o=1 for exactly one cycle, update_content_o=PTE, update_vpn_o=vaddr[38:12], update_asid_o=captured ASID, is_1G=(level==2), is_2M=(level==1); return IDLE.
REQ-021 Fault: next cycle walk_error_o=1 for one cycle, no update; return IDLE.
REQ-022 update_valid_o and walk_error_o SHALL never both be 1.
REQ-023 flush_i in REQ before handshake: drop request, go IDLE next cycle; on the same cycle as handshake, or in WAIT: go ABORT.
REQ-024 ABORT: wait for the outstanding response, discard it, go IDLE; no update, no error.
REQ-025 flush_i coincident with mem_rsp_valid_i in WAIT SHALL discard the response and go IDLE.
REQ-026 busy_o=1 in all states except IDLE; a new walk is accepted one cycle after update/error at the earliest.
REQ-027 Minimum latency: accept at cycle 0, first mem_req_valid_o at cycle 1; with zero-wait memory a 4 KiB walk issues update at cycle N+1, N = cycle of the third response.

Reset
REQ-028 On rst_ni=0, state SHALL be IDLE, with all outputs 0 except walk_ready_o=1, and all captured registers 0.
REQ-029 Reset assertion mid-walk SHALL abandon the walk immediately; any late memory response is ignored after reset.

Verification
REQ-030 satp_ppn=0x100, vaddr=0x40201000, three pointer/leaf PTEs (leaf PPN 0x80000, RWXV) -> addresses 0x100008, 0x(L1)008, 0x(L0)008; update is_2M=0, is_1G=0, vpn=0x40201.
REQ-031 Level-2 leaf PTE with PPN 0x40000 -> one memory request, update is_1G=1; same with PPN 0x40001 -> walk_error_o pulse, no update.
REQ-032 Level-1 PTE with V=0 -> walk_error_o after two requests; PTE with R=0, W=1 -> fault.
REQ-033 flush_i asserted in WAIT with response 5 cycles later -> ABORT absorbs it, no update/error, walk_ready_o returns 1 the cycle after.
REQ-034 mem_req_ready_i held low 4 cycles -> mem_req_addr_o stable, exactly one request accepted.
REQ-035 rst_ni pulsed low during level-1 WAIT -> IDLE, walk_ready_o=1, stray response produces no update.
